// File: rtl/melody_sequencer_if.sv
// ---------------------------------------------------------------------------
// melody_sequencer_if
//   Bundles the control, keyboard and buzzer signals of melody_sequencer.
//
//   Signalling: there is no valid/ready handshake on this block. play and
//   stop are one-cycle pulses sampled on the rising clock edge. key_valid is
//   a level: while it is high the keyboard owns the buzzer and key_note is
//   sampled every edge. All outputs are registered.
//
//   Signals
//     play       master->slave  start-playback pulse
//     stop       master->slave  abort-playback pulse (wins over play)
//     key_valid  master->slave  keyboard requests the buzzer
//     key_note   master->slave  keyboard note code 1-14, 0 = silence
//     sound      slave->master  note code to the buzzer datapath
//     note_on    slave->master  buzzer enable
//     owner      slave->master  1 = sequencer drives sound
//     busy       slave->master  song in progress (also while held)
//     step_idx   slave->master  current song step 0-15
//     state_dbg  slave->master  FSM state (IDLE=0, NOTE=1, GAP=2, HOLD=3)
// ---------------------------------------------------------------------------
interface melody_sequencer_if;
    logic       play;
    logic       stop;
    logic       key_valid;
    logic [3:0] key_note;
    logic [3:0] sound;
    logic       note_on;
    logic       owner;
    logic       busy;
    logic [3:0] step_idx;
    logic [1:0] state_dbg;

    modport master (
        output play, stop, key_valid, key_note,
        input  sound, note_on, owner, busy, step_idx, state_dbg
    );

    modport slave (
        input  play, stop, key_valid, key_note,
        output sound, note_on, owner, busy, step_idx, state_dbg
    );
endinterface

// File: rtl/melody_sequencer.sv
// ---------------------------------------------------------------------------
// melody_sequencer
//   Plays a fixed 16-step song on a buzzer. Step i plays note (i mod 14)+1
//   for ((i & 3)+1) beats; the last GAP_CYC cycles of every step are silent.
//   The keyboard can take the buzzer at any time; a running song is then
//   frozen in HOLD and resumes exactly where it stopped.
//
//   Parameters
//     BEAT_CYC  clock cycles per beat
//     GAP_CYC   silent cycles ending every step (1 <= GAP_CYC < BEAT_CYC)
//
//   Ports
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    melody_sequencer_if.slave (play/stop/keyboard in, buzzer out)
//
//   Build option
//     LOOP_EN  when defined, the song wraps from step 15 back to step 0;
//              otherwise the end of the song returns to IDLE.
// ---------------------------------------------------------------------------
module melody_sequencer #(
    parameter int BEAT_CYC = 25000000,
    parameter int GAP_CYC  = 1000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    melody_sequencer_if.slave         bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [27:0] BEAT_W = 28'(BEAT_CYC);
    localparam logic [27:0] GAP_W  = 28'(GAP_CYC);

    state_t      state_q,   state_d;
    state_t      ret_q,     ret_d;      // state to resume when HOLD ends
    logic [27:0] cnt_q,     cnt_d;
    logic [3:0]  step_q,    step_d;
    logic [3:0]  sound_q,   sound_d;
    logic        note_on_q, note_on_d;
    logic        owner_q,   owner_d;
    logic        busy_q,    busy_d;

    // Where the song would be after this edge if the keyboard were idle.
    state_t      tgt_state;
    logic [27:0] tgt_cnt;
    logic [3:0]  tgt_step;

    function automatic logic [3:0] step_note(input logic [3:0] i);
        if (i == 4'd14)      return 4'd1;
        else if (i == 4'd15) return 4'd2;
        else                 return i + 4'd1;
    endfunction

    // Audible part of a step: the full step length minus the trailing gap.
    function automatic logic [27:0] note_len(input logic [3:0] i);
        logic [27:0] beats;
        beats = 28'(i[1:0]) + 28'd1;
        return beats * BEAT_W - GAP_W;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ret_q     <= NOTE;
            cnt_q     <= '0;
            step_q    <= '0;
            sound_q   <= '0;
            note_on_q <= 1'b0;
            owner_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            sound_q   <= sound_d;
            note_on_q <= note_on_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
        end
    end

    // Sequencer advance, ignoring keyboard and stop.
    always_comb begin
        tgt_state = state_q;
        tgt_cnt   = cnt_q;
        tgt_step  = step_q;
        case (state_q)
            IDLE: begin
                tgt_cnt  = '0;
                tgt_step = '0;
                if (bus.play) tgt_state = NOTE;
            end
            NOTE: begin
                if (cnt_q == note_len(step_q) - 28'd1) begin
                    tgt_state = GAP;
                    tgt_cnt   = '0;
                end else begin
                    tgt_cnt = cnt_q + 28'd1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_W - 28'd1) begin
                    tgt_cnt = '0;
                    if (step_q != 4'd15) begin
                        tgt_state = NOTE;
                        tgt_step  = step_q + 4'd1;
                    end else begin
                        tgt_step = '0;
`ifdef LOOP_EN
                        tgt_state = NOTE;
`else
                        tgt_state = IDLE;
`endif
                    end
                end else begin
                    tgt_cnt = cnt_q + 28'd1;
                end
            end
            HOLD: begin
                // Frozen: resume exactly where the song was interrupted.
                tgt_state = ret_q;
            end
            default: tgt_state = IDLE;
        endcase
    end

    // Arbitration between stop, keyboard and sequencer; computes every
    // registered output together with the state it belongs to.
    always_comb begin
        state_d   = tgt_state;
        ret_d     = ret_q;
        cnt_d     = tgt_cnt;
        step_d    = tgt_step;
        sound_d   = step_note(tgt_step);
        note_on_d = (tgt_state == NOTE);
        owner_d   = 1'b1;
        busy_d    = 1'b1;

        if (bus.stop) begin
            state_d   = IDLE;
            cnt_d     = '0;
            step_d    = '0;
            sound_d   = '0;
            note_on_d = 1'b0;
            owner_d   = 1'b0;
            busy_d    = 1'b0;
        end else if (tgt_state == IDLE) begin
            state_d   = IDLE;
            cnt_d     = '0;
            step_d    = '0;
            busy_d    = 1'b0;
            owner_d   = 1'b0;
            sound_d   = bus.key_valid ? bus.key_note : 4'd0;
            note_on_d = bus.key_valid && (bus.key_note != 4'd0);
        end else if (bus.key_valid) begin
            // Park the would-be next position; count and step stay frozen.
            state_d   = HOLD;
            ret_d     = tgt_state;
            sound_d   = bus.key_note;
            note_on_d = (bus.key_note != 4'd0);
            owner_d   = 1'b0;
        end
    end

    assign bus.sound     = sound_q;
    assign bus.note_on   = note_on_q;
    assign bus.owner     = owner_q;
    assign bus.busy      = busy_q;
    assign bus.step_idx  = step_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// ---------------------------------------------------------------------------
// tb_melody_sequencer
//   Directed bench for melody_sequencer with BEAT_CYC=8, GAP_CYC=2.
//   Cycle k is the period right after the edge that samples play.
// ---------------------------------------------------------------------------
module tb_melody_sequencer;
    localparam int BEAT = 8;
    localparam int GAP  = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    melody_sequencer_if bus ();

    melody_sequencer #(
        .BEAT_CYC(BEAT),
        .GAP_CYC (GAP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check_out(input string tag, input int snd, input int on,
                             input int own, input int bsy, input int stp);
        check({tag, ".sound"},    32'(bus.sound),    32'(snd));
        check({tag, ".note_on"},  32'(bus.note_on),  32'(on));
        check({tag, ".owner"},    32'(bus.owner),    32'(own));
        check({tag, ".busy"},     32'(bus.busy),     32'(bsy));
        check({tag, ".step_idx"}, 32'(bus.step_idx), 32'(stp));
    endtask

    task automatic pulse_play();
        bus.play = 1'b1;
        tick();
        bus.play = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    initial begin
        int cur;
        int off;

        bus.play      = 1'b0;
        bus.stop      = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_note  = 4'd0;
        rst_n         = 1'b0;
        ticks(3);
        check_out("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        check_out("post_reset", 0, 0, 0, 0, 0);

        // Basic timing, plus a play pulse while busy that must be ignored.
        pulse_play();
        check_out("start", 1, 1, 1, 1, 0);
        for (int c = 0; c < 24; c++) begin
            if (c < 6) begin
                check("s0_note.sound", 32'(bus.sound), 32'd1);
                check("s0_note.on",    32'(bus.note_on), 32'd1);
            end else if (c < 8) begin
                check("s0_gap.sound", 32'(bus.sound), 32'd1);
                check("s0_gap.on",    32'(bus.note_on), 32'd0);
            end else if (c < 22) begin
                check("s1_note.sound", 32'(bus.sound), 32'd2);
                check("s1_note.on",    32'(bus.note_on), 32'd1);
                check("s1_note.step",  32'(bus.step_idx), 32'd1);
            end else begin
                check("s1_gap.on",   32'(bus.note_on), 32'd0);
                check("s1_gap.step", 32'(bus.step_idx), 32'd1);
            end
            bus.play = (c == 10);
            tick();
        end
        bus.play = 1'b0;
        check_out("s2_start", 3, 1, 1, 1, 2);
        pulse_stop();
        check_out("stop_a", 0, 0, 0, 0, 0);

        // Keyboard override in NOTE of step 0.
        pulse_play();
        ticks(2);
        check_out("pre_key", 1, 1, 1, 1, 0);
        bus.key_valid = 1'b1;
        bus.key_note  = 4'd9;
        for (int c = 3; c < 8; c++) begin
            tick();
            check_out("hold", 9, 1, 0, 1, 0);
        end
        bus.key_valid = 1'b0;
        bus.key_note  = 4'd0;
        for (int c = 8; c < 11; c++) begin
            tick();
            check_out("resume_note", 1, 1, 1, 1, 0);
        end
        for (int c = 11; c < 13; c++) begin
            tick();
            check_out("resume_gap", 1, 0, 1, 1, 0);
        end
        tick();
        check_out("resume_s1", 2, 1, 1, 1, 1);
        pulse_stop();
        check_out("stop_b", 0, 0, 0, 0, 0);

        // Stop wins over play in IDLE; stop mid-song.
        bus.stop = 1'b1;
        bus.play = 1'b1;
        tick();
        bus.stop = 1'b0;
        bus.play = 1'b0;
        check_out("stop_play", 0, 0, 0, 0, 0);
        tick();
        check("stop_play.state", 32'(bus.state_dbg), 32'd0);
        pulse_play();
        ticks(20);
        check("k20.busy", 32'(bus.busy), 32'd1);
        pulse_stop();
        check_out("k21_stop", 0, 0, 0, 0, 0);

        // Keyboard in IDLE, then play together with a held key.
        bus.key_valid = 1'b1;
        bus.key_note  = 4'd5;
        tick();
        check_out("idle_key", 5, 1, 0, 0, 0);
        bus.key_note = 4'd0;
        tick();
        check_out("idle_key0", 0, 0, 0, 0, 0);
        bus.key_note = 4'd7;
        pulse_play();
        check_out("play_key", 7, 1, 0, 1, 0);
        check("play_key.state", 32'(bus.state_dbg), 32'd3);
        bus.key_valid = 1'b0;
        bus.key_note  = 4'd0;
        tick();
        check_out("play_key_rel", 1, 1, 1, 1, 0);
        ticks(5);
        check("play_key_last.on", 32'(bus.note_on), 32'd1);
        tick();
        check("play_key_gap.on", 32'(bus.note_on), 32'd0);
        pulse_stop();

        // Whole song: step starts and the end at k+320.
        pulse_play();
        cur = 0;
        off = 0;
        for (int i = 0; i < 16; i++) begin
            ticks(off - cur);
            cur = off;
            check("song.step",  32'(bus.step_idx), 32'(i));
            check("song.sound", 32'(bus.sound), 32'((i % 14) + 1));
            off += ((i & 3) + 1) * BEAT;
        end
        ticks(off - cur);
`ifdef LOOP_EN
        check_out("song_end", 1, 1, 1, 1, 0);
`else
        check_out("song_end", 0, 0, 0, 0, 0);
`endif
        pulse_stop();

        // Asynchronous reset in the middle of a note.
        pulse_play();
        ticks(10);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check_out("rst_release", 0, 0, 0, 0, 0);
        check("rst_release.state", 32'(bus.state_dbg), 32'd0);
        pulse_play();
        check_out("after_rst_play", 1, 1, 1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
